// File: rtl/hash_probe_ctrl_if.sv
// Bundled command, response and table-RAM signals of hash_probe_ctrl.
// With HASH_CLR_EN defined, the interface adds clr_start and mem_wr_vld.
interface hash_probe_ctrl_if #(
  parameter int KEY_W  = 8,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [KEY_W-1:0]  req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [ADDR_W-1:0] rsp_index;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [KEY_W-1:0]  mem_rd_key;
  logic              mem_rd_vld;
  logic              mem_wr_en;
  logic [KEY_W-1:0]  mem_wr_key;
  logic              busy;
`ifdef HASH_CLR_EN
  logic              clr_start;
  logic              mem_wr_vld;
`endif

  // master is the controller; slave is the requester plus the table RAM
  modport master (
    input  req_valid, req_op, req_key, rsp_ready, mem_rd_key, mem_rd_vld,
    output req_ready, rsp_valid, rsp_status, rsp_index,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_key, busy
`ifdef HASH_CLR_EN
    , input clr_start, output mem_wr_vld
`endif
  );

  modport slave (
    output req_valid, req_op, req_key, rsp_ready, mem_rd_key, mem_rd_vld,
    input  req_ready, rsp_valid, rsp_status, rsp_index,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_key, busy
`ifdef HASH_CLR_EN
    , output clr_start, input mem_wr_vld
`endif
  );
endinterface

// File: rtl/hash_probe_ctrl.sv
// Hash table probe sequencer: folded-XOR home slot, linear probing, one probe per two cycles.
// Optional table-clear sweep is compiled in with HASH_CLR_EN.
module hash_probe_ctrl #(
  parameter int KEY_W     = 8,
  parameter int ADDR_W    = 8,
  parameter int MAX_PROBE = 2**ADDR_W
) (
  input logic              clock,
  input logic              reset,
  hash_probe_ctrl_if.master bus
);
  localparam int NSLICE = (KEY_W + ADDR_W - 1) / ADDR_W;
  localparam int CNT_W  = $clog2(MAX_PROBE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PROBE);

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_CMP, S_WRITE, S_RESP
`ifdef HASH_CLR_EN
    , S_CLEAR
`endif
  } state_e;

  typedef enum logic [1:0] {
    ST_MISS = 2'b00, ST_HIT = 2'b01, ST_INS = 2'b10, ST_FULL = 2'b11
  } status_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  status_e           status_q, status_d;
  logic [ADDR_W-1:0] index_q, index_d;

  // Key is zero-padded to whole ADDR_W slices before folding.
  function automatic logic [ADDR_W-1:0] fold_hash(input logic [KEY_W-1:0] k);
    logic [NSLICE*ADDR_W-1:0] padded;
    logic [ADDR_W-1:0]        h;
    padded = '0;
    padded[KEY_W-1:0] = k;
    h = '0;
    for (int i = 0; i < NSLICE; i++) h ^= padded[i*ADDR_W +: ADDR_W];
    return h;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    status_d      = status_q;
    index_d       = index_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
`ifdef HASH_CLR_EN
    bus.mem_wr_vld = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef HASH_CLR_EN
        bus.req_ready = !bus.clr_start;
        if (bus.clr_start) begin
          addr_d  = '0;
          state_d = S_CLEAR;
        end else
`else
        bus.req_ready = 1'b1;
`endif
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          key_d   = bus.req_key;
          addr_d  = fold_hash(bus.req_key);
          cnt_d   = '0;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        bus.mem_rd_en = 1'b1;
        state_d       = S_CMP;
      end
      S_CMP: begin
        if (bus.mem_rd_vld && bus.mem_rd_key == key_q) begin
          status_d = ST_HIT;
          index_d  = addr_q;
          state_d  = S_RESP;
        end else if (!bus.mem_rd_vld) begin
          if (op_q) begin
            state_d = S_WRITE;
          end else begin
            status_d = ST_MISS;
            index_d  = addr_q;
            state_d  = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == MAX_CNT) begin
            status_d = op_q ? ST_FULL : ST_MISS;
            index_d  = addr_q;
            state_d  = S_RESP;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_PROBE;
          end
        end
      end
      S_WRITE: begin
        bus.mem_wr_en = 1'b1;
`ifdef HASH_CLR_EN
        bus.mem_wr_vld = 1'b1;
`endif
        status_d = ST_INS;
        index_d  = addr_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
`ifdef HASH_CLR_EN
      S_CLEAR: begin
        bus.mem_wr_en = 1'b1;
        addr_d        = addr_q + 1'b1;
        if (addr_q == '1) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wr_key = key_q;
  assign bus.rsp_status = status_q;
  assign bus.rsp_index  = index_q;

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      key_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      status_q <= ST_MISS;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      index_q  <= index_d;
    end
  end
endmodule

// File: tb/tb_hash_probe_ctrl.sv
// Directed bench for hash_probe_ctrl (ADDR_W=4, KEY_W=8, MAX_PROBE=16) with a 1-cycle-read table RAM model.
module tb_hash_probe_ctrl;
  logic clock;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   both_cnt     = 0;

  logic [7:0] ram_key [16];
  logic       ram_vld [16];

  hash_probe_ctrl_if #(.KEY_W(8), .ADDR_W(4)) bus ();

  hash_probe_ctrl #(.KEY_W(8), .ADDR_W(4), .MAX_PROBE(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // NOTE: the RAM model is deliberately not reset; a controller reset must leave table contents alone.
  always @(posedge clock) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_key <= ram_key[bus.mem_addr];
      bus.mem_rd_vld <= ram_vld[bus.mem_addr];
    end
    if (bus.mem_wr_en) begin
      ram_key[bus.mem_addr] <= bus.mem_wr_key;
      ram_vld[bus.mem_addr] <= 1'b1;
    end
  end

  always @(negedge clock) if (bus.mem_rd_en && bus.mem_wr_en) both_cnt++;

  // Issues one command from IDLE; lat counts cycles from the accept cycle T until rsp_valid.
  task automatic run_cmd(input logic op, input logic [7:0] key,
                         output logic [1:0] st, output logic [3:0] idx, output int lat,
                         output int n_rd, output int n_wr, output int wr_cyc, output logic [3:0] wr_addr);
    lat = 0; n_rd = 0; n_wr = 0; wr_cyc = -1; wr_addr = '0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_key   = 8'hAA;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.mem_rd_en) n_rd++;
      if (bus.mem_wr_en) begin
        n_wr++;
        wr_cyc  = lat;
        wr_addr = bus.mem_addr;
      end
      @(posedge clock); #1;
      lat++;
    end
    st  = bus.rsp_status;
    idx = bus.rsp_index;
    if (bus.rsp_ready) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #3;
    tests_run++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.mem_rd_en, bus.mem_wr_en} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 10000 (req_ready,rsp_valid,busy,rd_en,wr_en)",
               {bus.req_ready, bus.rsp_valid, bus.busy, bus.mem_rd_en, bus.mem_wr_en});
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_wr_key, bus.rsp_status, bus.rsp_index} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 0 (addr,wr_key,status,index)",
               {bus.mem_addr, bus.mem_wr_key, bus.rsp_status, bus.rsp_index});
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_insert_lookup;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    run_cmd(1'b1, 8'h35, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b10, 4'd6} || lat != 4) begin
      tests_failed++;
      $display("FAIL ins_35: got st=%b idx=%0d lat=%0d want st=10 idx=6 lat=4", st, idx, lat);
    end
    tests_run++;
    if (nw != 1 || wc != 3 || wa !== 4'd6) begin
      tests_failed++;
      $display("FAIL ins_35_write: got n=%0d cyc=%0d addr=%0d want n=1 cyc=3 addr=6", nw, wc, wa);
    end
    run_cmd(1'b0, 8'h35, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b01, 4'd6} || lat != 3 || nw != 0) begin
      tests_failed++;
      $display("FAIL look_35: got st=%b idx=%0d lat=%0d wr=%0d want st=01 idx=6 lat=3 wr=0", st, idx, lat, nw);
    end
  endtask

  task automatic test_collision_wrap;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    run_cmd(1'b1, 8'h53, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b10, 4'd7} || lat != 6 || nr != 2 || wa !== 4'd7) begin
      tests_failed++;
      $display("FAIL ins_53: got st=%b idx=%0d lat=%0d rd=%0d wa=%0d want 10 7 6 2 7", st, idx, lat, nr, wa);
    end
    run_cmd(1'b1, 8'h0F, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b10, 4'd15} || lat != 4) begin
      tests_failed++;
      $display("FAIL ins_0f: got st=%b idx=%0d lat=%0d want st=10 idx=15 lat=4", st, idx, lat);
    end
    run_cmd(1'b1, 8'hF0, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b10, 4'd0} || lat != 6 || wa !== 4'd0) begin
      tests_failed++;
      $display("FAIL ins_f0_wrap: got st=%b idx=%0d lat=%0d wa=%0d want st=10 idx=0 lat=6 wa=0", st, idx, lat, wa);
    end
  endtask

  task automatic test_lookup;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    run_cmd(1'b0, 8'h53, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b01, 4'd7} || lat != 5) begin
      tests_failed++;
      $display("FAIL look_53: got st=%b idx=%0d lat=%0d want st=01 idx=7 lat=5", st, idx, lat);
    end
    run_cmd(1'b0, 8'h62, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b00, 4'd4} || lat != 3 || nw != 0) begin
      tests_failed++;
      $display("FAIL look_62_miss: got st=%b idx=%0d lat=%0d wr=%0d want st=00 idx=4 lat=3 wr=0", st, idx, lat, nw);
    end
  endtask

  task automatic test_dup_insert;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    run_cmd(1'b1, 8'h35, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b01, 4'd6} || nw != 0 || lat != 3) begin
      tests_failed++;
      $display("FAIL dup_35: got st=%b idx=%0d wr=%0d lat=%0d want st=01 idx=6 wr=0 lat=3", st, idx, nw, lat);
    end
  endtask

  task automatic test_full;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    for (int s = 1; s < 15; s++) begin
      if (s == 6 || s == 7) continue;
      run_cmd(1'b1, 8'(s), st, idx, lat, nr, nw, wc, wa);
      tests_run++;
      if ({st, idx} !== {2'b10, 4'(s)} || lat != 4) begin
        tests_failed++;
        $display("FAIL fill_%0d: got st=%b idx=%0d lat=%0d want st=10 idx=%0d lat=4", s, st, idx, lat, s);
      end
    end
    run_cmd(1'b1, 8'h99, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b11, 4'd15} || nr != 16 || nw != 0 || lat != 33) begin
      tests_failed++;
      $display("FAIL ins_full: got st=%b idx=%0d rd=%0d wr=%0d lat=%0d want 11 15 16 0 33", st, idx, nr, nw, lat);
    end
    run_cmd(1'b0, 8'h77, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if (st !== 2'b00 || nr != 16 || nw != 0 || lat != 33) begin
      tests_failed++;
      $display("FAIL look_absent: got st=%b rd=%0d wr=%0d lat=%0d want st=00 rd=16 wr=0 lat=33", st, nr, nw, lat);
    end
  endtask

  task automatic test_stall_reset;
    logic [1:0] st; logic [3:0] idx, wa; int lat, nr, nw, wc;
    int bad;
    bus.rsp_ready = 1'b0;
    run_cmd(1'b0, 8'h35, st, idx, lat, nr, nw, wc, wa);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({bus.rsp_valid, bus.req_ready, bus.busy, bus.rsp_status, bus.rsp_index} !== {3'b101, 2'b01, 4'd6}) bad++;
      @(posedge clock); #1;
    end
    tests_run++;
    if (bad != 0 || lat != 3) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d unstable cycles lat=%0d want 0 unstable lat=3", bad, lat);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_release: got rsp_valid,req_ready=%b want 01", {bus.rsp_valid, bus.req_ready});
    end

    // Insert of 0x20 hits a full slot 2; abort it in CMP before any write can issue.
    bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_key = 8'h20;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
         bus.mem_wr_key, bus.rsp_status, bus.rsp_index} !== {5'b10000, 18'd0}) begin
      tests_failed++;
      $display("FAIL reset_in_cmp: got %h want %h", {bus.req_ready, bus.rsp_valid, bus.busy,
               bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_key, bus.rsp_status, bus.rsp_index},
               {5'b10000, 18'd0});
    end
    nw = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      if (bus.mem_wr_en || bus.rsp_valid) nw++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (bus.mem_wr_en || bus.rsp_valid) nw++;
    end
    tests_run++;
    if (nw != 0 || ram_key[2] !== 8'h02 || ram_vld[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_no_side_effect: got %0d stray cycles slot2=%h/%b want 0 02/1", nw, ram_key[2], ram_vld[2]);
    end
    run_cmd(1'b0, 8'h53, st, idx, lat, nr, nw, wc, wa);
    tests_run++;
    if ({st, idx} !== {2'b01, 4'd7} || lat != 5) begin
      tests_failed++;
      $display("FAIL post_reset_cmd: got st=%b idx=%0d lat=%0d want st=01 idx=7 lat=5", st, idx, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_key[i] = 8'h00;
      ram_vld[i] = 1'b0;
    end
    bus.mem_rd_key = 8'h00;
    bus.mem_rd_vld = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_key    = 8'h00;
    bus.rsp_ready  = 1'b1;
    test_reset;
    test_insert_lookup;
    test_collision_wrap;
    test_lookup;
    test_dup_insert;
    test_full;
    test_stall_reset;
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL rd_wr_exclusive: got %0d overlapping cycles want 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
